// File: rtl/auth_key_blk_if.sv
// Signal bundle between the authentication block and its environment:
// UART line and rider sensing in, power/status indications out.
interface auth_key_blk_if;
  logic RX;
  logic rider_off;
  logic pwr_up;
  logic auth_fail;
  logic locked;

  modport master (
    output RX,
    output rider_off,
    input  pwr_up,
    input  auth_fail,
    input  locked
  );

  modport slave (
    input  RX,
    input  rider_off,
    output pwr_up,
    output auth_fail,
    output locked
  );
endinterface

// File: rtl/auth_key_blk.sv
// auth_key_blk: GO + multi-byte passcode authentication for the power path,
// with rider_off hold-off, inter-byte timeout and lockout after repeated
// failures. UART_rx (8N1, BAUD_DIV clk cycles per bit) is bundled here so
// the block is self-contained; BAUD_DIV is passed straight through to it.

module UART_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t      st_q, st_d;
  logic           rx_meta_q, rx_sync_q;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           rdy_q, rdy_d;

  // Synchroniser and receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      st_q      <= RX_IDLE;
      baud_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      st_q      <= st_d;
      baud_q    <= baud_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rdy_q     <= rdy_d;
    end
  end

  // Frame sequencing: verify start at half bit, then sample each bit mid-cell
  always_comb begin
    st_d    = st_q;
    baud_d  = baud_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    rdy_d   = rdy_q & ~clr_rdy;
    case (st_q)
      RX_IDLE: begin
        baud_d = '0;
        if (!rx_sync_q) st_d = RX_START;
      end
      RX_START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          bcnt_d = '0;
          st_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) st_d = RX_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          rdy_d  = 1'b1;
          st_d   = RX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_data = shift_q;
  assign rdy     = rdy_q;
endmodule

module auth_key_blk #(
  parameter logic [7:0]  GO_BYTE   = 8'h67,
  parameter logic [7:0]  STOP_BYTE = 8'h73,
  parameter int          KEY_LEN   = 2,
  parameter logic [63:0] KEY       = 64'h0,
  parameter logic [23:0] KEY_TMO   = 24'd5_000_000,
  parameter logic [19:0] OFF_DLY   = 20'd500_000,
  parameter int          MAX_FAIL  = 3,
  parameter logic [27:0] LOCK_CYC  = 28'd250_000_000,
  parameter int          BAUD_DIV  = 2604
) (
  input logic          clk,
  input logic          rst_n,
  auth_key_blk_if.slave bus
);
  localparam int IDX_W  = (KEY_LEN > 0) ? $clog2(KEY_LEN + 1) : 1;
  localparam int TMO_W  = (KEY_TMO > 24'd1) ? $clog2(KEY_TMO) : 1;
  localparam int OFF_W  = (OFF_DLY > 20'd1) ? $clog2(OFF_DLY) : 1;
  localparam int LOCK_W = (LOCK_CYC > 28'd1) ? $clog2(LOCK_CYC) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(KEY_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(KEY_TMO - 24'd1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(OFF_DLY - 20'd1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 28'd1);
  localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAIL);
  // Passcode left-justified so byte i always sits at bits [63-8i -: 8]
  localparam logic [63:0]       KEY_SH    = KEY << (8 * (8 - KEY_LEN));

  typedef enum logic [2:0] {S_OFF, S_KEY, S_PWR1, S_PWR2, S_LOCK} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mis_q, mis_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              af_q, af_d;

  logic [7:0]        rx_data;
  logic              rdy;
  logic              clr_rdy;
  logic [2:0]        idx3;
  logic [7:0]        exp_byte;
  logic              mis_now;
  logic              do_fail;
  logic [FAIL_W-1:0] fail_inc;

  UART_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (bus.RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

  // Every byte is consumed in the cycle it is first presented, in any state
  assign clr_rdy  = rdy;
  assign idx3     = 3'(idx_q);
  assign exp_byte = KEY_SH[{~idx3, 3'b000} +: 8];
  assign mis_now  = mis_q | (rx_data != exp_byte);
  assign fail_inc = (fail_q == FAIL_LIM) ? fail_q : fail_q + FAIL_W'(1);

  // Control state, counters and registered fail pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= '0;
      off_q   <= '0;
      lock_q  <= '0;
      fail_q  <= '0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      off_q   <= off_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
      af_q    <= af_d;
    end
  end

  // Next-state logic; a failure from KEY is resolved after the case so both
  // mismatch and timeout share one fail path
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    tmo_d   = tmo_q;
    off_d   = '0;
    lock_d  = '0;
    fail_d  = fail_q;
    af_d    = 1'b0;
    do_fail = 1'b0;
    case (state_q)
      S_OFF: begin
        if (rdy && (rx_data == GO_BYTE)) begin
          idx_d = '0;
          mis_d = 1'b0;
          tmo_d = '0;
          if (KEY_LEN == 0) begin
            state_d = S_PWR1;
            fail_d  = '0;
          end else begin
            state_d = S_KEY;
          end
        end
      end
      S_KEY: begin
        if (rdy) begin
          mis_d = mis_now;
          idx_d = idx_q + IDX_W'(1);
          tmo_d = '0;
          if (idx_q == IDX_LAST) begin
            if (!mis_now) begin
              state_d = S_PWR1;
              fail_d  = '0;
            end else begin
              do_fail = 1'b1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          do_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_PWR1: begin
        if (rdy && (rx_data == STOP_BYTE))
          state_d = bus.rider_off ? S_OFF : S_PWR2;
      end
      S_PWR2: begin
        if (rdy && (rx_data == GO_BYTE)) begin
          state_d = S_PWR1;
        end else if (bus.rider_off) begin
          if (off_q == OFF_LAST) state_d = S_OFF;
          else                   off_d   = off_q + OFF_W'(1);
        end
      end
      S_LOCK: begin
        if (lock_q == LOCK_LAST) begin
          state_d = S_OFF;
          fail_d  = '0;
        end else begin
          lock_d = lock_q + LOCK_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase

    if (do_fail) begin
      af_d    = 1'b1;
      fail_d  = fail_inc;
      state_d = (fail_inc == FAIL_LIM) ? S_LOCK : S_OFF;
    end
  end

  assign bus.pwr_up    = (state_q == S_PWR1) || (state_q == S_PWR2);
  assign bus.locked    = (state_q == S_LOCK);
  assign bus.auth_fail = af_q;
endmodule
